// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch unit.
//
// Fetches one instruction word from memory, holds it in IR until the control
// unit consumes it (PC_increment) or redirects (bra), then fetches the next.
// A halt request freezes the unit until reset.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (PC <= BADR, state <= IDLE)
//   BADR         boot address
//   bra          branch request (honoured in HOLD only)
//   br_target    branch destination, sampled with bra
//   PC_increment advance PC by one (honoured in HOLD only)
//   hlt          halt request; highest priority after rst
//   mem_addr     instruction memory address (= PC)
//   mem_rd       read strobe, high while fetching
//   mem_data     instruction word, valid with mem_ack
//   mem_ack      single-cycle read completion
//   PC           program counter
//   IR           instruction register
//   ir_valid     IR holds the instruction at PC
//   fetch_err    fetch timeout flag
//
// Build option: define FETCH_TIMEOUT_EN to halt with fetch_err=1 after 16
// consecutive FETCH cycles without mem_ack. Otherwise fetch_err is tied low
// and FETCH waits indefinitely.

module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  BADR,
  input  logic        bra,
  input  logic [9:0]  br_target,
  input  logic        PC_increment,
  input  logic        hlt,
  output logic [9:0]  mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_ack,
  output logic [9:0]  PC,
  output logic [15:0] IR,
  output logic        ir_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   ld_ir;
  logic   pc_inc;
  logic   pc_br;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] to_cnt;
  logic       timeout;

  // Counter value 15 marks the 16th consecutive FETCH cycle without an ack.
  assign timeout = (state == FETCH) && !mem_ack && (to_cnt == 4'hF);
`endif

  assign mem_addr = PC;
  assign mem_rd   = (state == FETCH);

  always_comb begin
    state_nxt = state;
    ld_ir     = 1'b0;
    pc_inc    = 1'b0;
    pc_br     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = hlt ? HALT : FETCH;
      end
      FETCH: begin
        if (hlt) begin
          state_nxt = HALT;
        end else if (mem_ack) begin
          ld_ir     = 1'b1;
          state_nxt = HOLD;
`ifdef FETCH_TIMEOUT_EN
        end else if (timeout) begin
          state_nxt = HALT;
`endif
        end
      end
      HOLD: begin
        if (hlt) begin
          state_nxt = HALT;
        end else if (bra) begin
          pc_br     = 1'b1;
          state_nxt = FETCH;
        end else if (PC_increment) begin
          pc_inc    = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      PC       <= BADR;
      IR       <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pc_br) begin
        PC <= br_target;
      end else if (pc_inc) begin
        PC <= PC + 10'd1;
      end
      if (ld_ir) begin
        IR       <= mem_data;
        ir_valid <= 1'b1;
      end else if (pc_br || pc_inc) begin
        ir_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Held at zero outside FETCH, so the count restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state != FETCH) begin
        to_cnt <= '0;
      end else if (!mem_ack) begin
        to_cnt <= to_cnt + 4'd1;
      end
      if (timeout && !hlt) begin
        fetch_err <= 1'b1;
      end
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with an IR scoreboard:
// each acknowledged fetch pushes its data word, and the word is popped and
// compared against IR when ir_valid is observed.

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  BADR;
  logic        bra;
  logic [9:0]  br_target;
  logic        PC_increment;
  logic        hlt;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic [9:0]  PC;
  logic [15:0] IR;
  logic        ir_valid;
  logic        fetch_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_ir;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .BADR        (BADR),
    .bra         (bra),
    .br_target   (br_target),
    .PC_increment(PC_increment),
    .hlt         (hlt),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .PC          (PC),
    .IR          (IR),
    .ir_valid    (ir_valid),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits up to 'stall' cycles with mem_ack low (checking the strobe stays up),
  // then acks with 'data' and checks the scoreboard on the following cycle.
  task automatic do_fetch(input logic [15:0] data, input int unsigned stall);
    logic [15:0] exp;
    for (int unsigned i = 0; i < stall; i++) begin
      step();
      check("stall_mem_rd", {31'd0, mem_rd}, 32'd1);
    end
    mem_ack  = 1'b1;
    mem_data = data;
    exp_q.push_back(data);
    step();
    mem_ack  = 1'b0;
    mem_data = 16'hxxxx;
    check("ack_ir_valid", {31'd0, ir_valid}, 32'd1);
    check("ack_mem_rd", {31'd0, mem_rd}, 32'd0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check("ir_data", {16'd0, IR}, {16'd0, exp});
    end
  endtask

  task automatic do_incr(input logic [9:0] exp_pc);
    PC_increment = 1'b1;
    step();
    PC_increment = 1'b0;
    check("inc_pc", {22'd0, PC}, {22'd0, exp_pc});
    check("inc_mem_addr", {22'd0, mem_addr}, {22'd0, exp_pc});
    check("inc_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("inc_ir_valid", {31'd0, ir_valid}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    BADR         = 10'd15;
    bra          = 1'b0;
    br_target    = '0;
    PC_increment = 1'b0;
    hlt          = 1'b0;
    mem_data     = '0;
    mem_ack      = 1'b0;

    // Reset state
    step();
    check("rst_pc", {22'd0, PC}, 32'd15);
    check("rst_ir", {16'd0, IR}, 32'd0);
    check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

    // First read strobe one cycle after release
    rst = 1'b0;
    step();
    check("boot_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("boot_mem_addr", {22'd0, mem_addr}, 32'd15);

    // Minimum-latency fetch
    do_fetch(16'hA5C3, 0);
    check("hold_pc", {22'd0, PC}, 32'd15);

    // HOLD with no request stays put
    step();
    check("hold_stable_ir", {16'd0, IR}, 32'hA5C3);
    check("hold_stable_valid", {31'd0, ir_valid}, 32'd1);
    check("hold_stable_rd", {31'd0, mem_rd}, 32'd0);

    do_incr(10'd16);

    // bra / PC_increment ignored while fetching
    bra = 1'b1; br_target = 10'd5; PC_increment = 1'b1;
    step();
    bra = 1'b0; PC_increment = 1'b0;
    check("fetch_ignore_pc", {22'd0, PC}, 32'd16);
    check("fetch_ignore_rd", {31'd0, mem_rd}, 32'd1);

    // Stalled fetches, walk PC to 20
    do_fetch(16'h0011, 3);
    do_incr(10'd17);
    do_fetch(16'h0022, 1);
    do_incr(10'd18);
    do_fetch(16'h0033, 0);
    do_incr(10'd19);
    do_fetch(16'h0044, 2);
    do_incr(10'd20);
    do_fetch(16'hBEEF, 0);

    // bra beats coincident PC_increment
    bra = 1'b1; br_target = 10'h3FF; PC_increment = 1'b1;
    step();
    bra = 1'b0; PC_increment = 1'b0;
    check("bra_pc", {22'd0, PC}, 32'h3FF);
    check("bra_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("bra_ir_valid", {31'd0, ir_valid}, 32'd0);

    // Wrap at top of address space
    do_fetch(16'h7E7E, 1);
    do_incr(10'h000);

    // Halt during FETCH with coincident ack
    last_ir = IR;
    hlt = 1'b1; mem_ack = 1'b1; mem_data = 16'h1234;
    step();
    hlt = 1'b0; mem_ack = 1'b0;
    check("halt_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("halt_ir", {16'd0, IR}, {16'd0, last_ir});
    check("halt_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("halt_pc", {22'd0, PC}, 32'd0);

    // HALT is sticky against all non-reset inputs
    mem_ack = 1'b1; bra = 1'b1; br_target = 10'd99; PC_increment = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("halt_sticky_rd", {31'd0, mem_rd}, 32'd0);
    end
    mem_ack = 1'b0; bra = 1'b0; PC_increment = 1'b0;
    check("halt_sticky_pc", {22'd0, PC}, 32'd0);
    check("halt_sticky_ir", {16'd0, IR}, {16'd0, last_ir});

    // Reset from HALT with coincident ack
    BADR = 10'd15;
    rst = 1'b1; mem_ack = 1'b1; mem_data = 16'hDEAD;
    step();
    rst = 1'b0; mem_ack = 1'b0;
    check("rst2_pc", {22'd0, PC}, 32'd15);
    check("rst2_ir", {16'd0, IR}, 32'd0);
    check("rst2_mem_rd", {31'd0, mem_rd}, 32'd0);
    step();
    check("rst2_boot_rd", {31'd0, mem_rd}, 32'd1);
    check("rst2_boot_addr", {22'd0, mem_addr}, 32'd15);

    // Timeout behaviour with mem_ack held low
`ifdef FETCH_TIMEOUT_EN
    for (int unsigned i = 0; i < 15; i++) begin
      step();
    end
    check("to_pre_err", {31'd0, fetch_err}, 32'd0);
    check("to_pre_rd", {31'd0, mem_rd}, 32'd1);
    step();
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_halt_rd", {31'd0, mem_rd}, 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
    end
    check("to_err_sticky", {31'd0, fetch_err}, 32'd1);
    check("to_halt_sticky", {31'd0, mem_rd}, 32'd0);
`else
    for (int unsigned i = 0; i < 100; i++) begin
      step();
    end
    check("noto_rd", {31'd0, mem_rd}, 32'd1);
    check("noto_err", {31'd0, fetch_err}, 32'd0);
    do_fetch(16'hC0DE, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
